// File: rtl/switch_port_rx.sv
// Egress-port receiver: accepts switch words with a registered one-cycle
// acknowledge, buffers them in a show-ahead FIFO and drains via valid/ready.
module switch_port_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          port_req,
  input  logic [DATA_WIDTH-1:0]         port_data,
  output logic                          port_received,
  input  logic                          rx_enable,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_WIDTH-1:0]          rx_count,
  output logic                          proto_err,
  input  logic                          clr_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_LEVEL = FIFO_DEPTH[PTR_W:0];

  typedef enum logic {IDLE, ACK} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  accept;
  logic                  pop;

  // Full test looks only at the registered level, so a same-cycle pop never frees a slot early.
  assign accept    = (state == IDLE) && port_req && rx_enable && (fifo_level < FULL_LEVEL);
  assign pop       = (fifo_level != '0) && out_ready;
  assign out_valid = (fifo_level != '0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      port_received <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_level    <= '0;
      rx_count      <= '0;
      proto_err     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // port_received is a flop output so the switch can drop port_req off it combinationally.
      case (state)
        IDLE: begin
          if (accept) begin
            state         <= ACK;
            port_received <= 1'b1;
          end
        end
        ACK: begin
          state         <= IDLE;
          port_received <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          port_received <= 1'b0;
        end
      endcase

      if (accept) begin
        mem[wr_ptr] <= port_data;
        wr_ptr      <= wr_ptr + 1'b1;
        if (rx_count != '1) begin
          rx_count <= rx_count + 1'b1;
        end
      end

      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({accept, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase

      // A request still held during the acknowledge cycle is a protocol violation; set beats clear.
      if ((state == ACK) && port_req) begin
        proto_err <= 1'b1;
      end else if (clr_err) begin
        proto_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_switch_port_rx.sv
// Bench for switch_port_rx: queue-based reference model plus scoreboard, with
// a second instance using a 2-bit counter to exercise saturation.
module tb_switch_port_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       port_req = 1'b0;
  logic [7:0] port_data = '0;
  logic       rx_enable = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_err = 1'b0;

  logic       port_received, out_valid, proto_err;
  logic [7:0] out_data;
  logic [2:0] fifo_level;
  logic [15:0] rx_count;

  logic       port_received2, out_valid2, proto_err2;
  logic [7:0] out_data2;
  logic [2:0] fifo_level2;
  logic [1:0] rx_count2;

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0] modelQ[$];
  logic [7:0] sbQ[$];
  bit expAck = 0;
  bit expProto = 0;
  int expCount = 0;
  int expCount2 = 0;
  int maxLevel = 0;
  bit done = 0;
  bit got;

  switch_port_rx #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .port_req(port_req), .port_data(port_data),
    .port_received(port_received), .rx_enable(rx_enable), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .fifo_level(fifo_level),
    .rx_count(rx_count), .proto_err(proto_err), .clr_err(clr_err)
  );

  switch_port_rx #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .port_req(port_req), .port_data(port_data),
    .port_received(port_received2), .rx_enable(rx_enable), .out_valid(out_valid2),
    .out_data(out_data2), .out_ready(out_ready), .fifo_level(fifo_level2),
    .rx_count(rx_count2), .proto_err(proto_err2), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: a word is taken when no acknowledge is pending, the
  // request and enable are up and the queue (before this cycle's pop) has room.
  always @(posedge clk or negedge reset) begin
    int  sz;
    bit  doAcc, doPop, errSet;
    if (!reset) begin
      modelQ.delete();
      sbQ.delete();
      expAck = 0;
      expProto = 0;
      expCount = 0;
      expCount2 = 0;
    end else begin
      sz     = modelQ.size();
      doPop  = (sz != 0) && out_ready;
      doAcc  = !expAck && port_req && rx_enable && (sz < 4);
      errSet = expAck && port_req;
      expProto = errSet ? 1'b1 : (clr_err ? 1'b0 : expProto);
      expAck = doAcc;
      if (doPop) void'(modelQ.pop_front());
      if (doAcc) begin
        modelQ.push_back(port_data);
        sbQ.push_back(port_data);
        expCount  = (expCount  < 65535) ? expCount + 1 : expCount;
        expCount2 = (expCount2 < 3) ? expCount2 + 1 : expCount2;
      end
    end
  end

  // Monitor: checks every output on the falling edge and retires scoreboard
  // entries whenever the DUT hands a word to the consumer.
  always @(negedge clk) begin
    checkOutput("port_received", port_received, expAck);
    checkOutput("out_valid", out_valid, modelQ.size() != 0);
    checkOutput("fifo_level", fifo_level, modelQ.size());
    checkOutput("rx_count", rx_count, expCount);
    checkOutput("rx_count_sat", rx_count2, expCount2);
    checkOutput("proto_err", proto_err, expProto);
    if (out_valid && modelQ.size() != 0) checkOutput("head_word", out_data, modelQ[0]);
    if (out_valid && out_ready) begin
      checkOutput("sb_nonempty", sbQ.size() != 0, 1);
      if (sbQ.size() != 0) checkOutput("sb_order", out_data, sbQ.pop_front());
    end
    if (int'(fifo_level) > maxLevel) maxLevel = fifo_level;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic [7:0] data);
    port_req  = req;
    port_data = data;
  endtask

  // Behaves like the switch: hold the request until the acknowledge is seen.
  task automatic sendWord(input logic [7:0] w, input int gap, output bit ok);
    ok = 0;
    applyStimulus(1'b1, w);
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (port_received) ok = 1;
    end
    applyStimulus(1'b0, w);
    repeat (gap) tick();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && fifo_level != 0; i++) tick();
    out_ready = 1'b0;
    checkOutput("drain_empty", fifo_level, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tick();
    tick();
    checkOutput("reset_out_data", out_data, 8'h00);
    checkOutput("reset_received", port_received, 0);
    reset = 1'b1;
    rx_enable = 1'b1;
    tick();

    // Single accept
    applyStimulus(1'b1, 8'hA5);
    tick();
    checkOutput("t1_ack", port_received, 1);
    applyStimulus(1'b0, 8'h00);
    checkOutput("t1_valid", out_valid, 1);
    checkOutput("t1_data", out_data, 8'hA5);
    checkOutput("t1_level", fifo_level, 1);
    checkOutput("t1_count", rx_count, 1);
    tick();
    checkOutput("t1_ack_once", port_received, 0);
    drain();

    // Fill, then a held fifth request stalls until a pop
    for (int i = 1; i <= 4; i++) begin
      sendWord(i[7:0], 3, got);
      checkOutput("t2_fill_ack", got, 1);
    end
    applyStimulus(1'b1, 8'h05);
    repeat (5) begin
      tick();
      checkOutput("t2_full_noack", port_received, 0);
      checkOutput("t2_full_level", fifo_level, 4);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("t2_pop_data", out_data, 8'h02);
    checkOutput("t2_pop_noack", port_received, 0);
    checkOutput("t2_pop_level", fifo_level, 3);
    tick();
    checkOutput("t2_fifth_ack", port_received, 1);
    checkOutput("t2_fifth_level", fifo_level, 4);
    applyStimulus(1'b0, 8'h00);
    tick();
    drain();

    // rx_enable low holds off the switch
    rx_enable = 1'b0;
    applyStimulus(1'b1, 8'h3C);
    repeat (10) begin
      tick();
      checkOutput("t3_dis_noack", port_received, 0);
      checkOutput("t3_dis_count", rx_count, 6);
    end
    rx_enable = 1'b1;
    tick();
    checkOutput("t3_en_ack", port_received, 1);
    checkOutput("t3_en_count", rx_count, 7);
    applyStimulus(1'b0, 8'h00);
    tick();

    // Protocol error: set, hold, clear, set-beats-clear
    applyStimulus(1'b1, 8'h11);
    tick();
    checkOutput("t4_ack", port_received, 1);
    tick();
    applyStimulus(1'b0, 8'h00);
    checkOutput("t4_err_set", proto_err, 1);
    repeat (3) tick();
    checkOutput("t4_err_sticky", proto_err, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checkOutput("t4_err_clr", proto_err, 0);
    applyStimulus(1'b1, 8'h22);
    tick();
    checkOutput("t4_ack2", port_received, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    applyStimulus(1'b0, 8'h00);
    checkOutput("t4_set_wins", proto_err, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checkOutput("t4_err_clr2", proto_err, 0);
    drain();

    // Streaming with a consumer always ready, across pointer wrap
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    maxLevel = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sendWord(8'($urandom), 3, got);
      checkOutput("t5_ack", got, 1);
    end
    out_ready = 1'b0;
    checkOutput("t5_count", rx_count, 20);
    checkOutput("t5_count_sat", rx_count2, 3);
    checkOutput("t5_max_level_le1", maxLevel <= 1, 1);
    checkOutput("t5_level", fifo_level, 0);

    // Reset landing in the acknowledge cycle
    applyStimulus(1'b1, 8'h77);
    tick();
    checkOutput("t6_ack", port_received, 1);
    reset = 1'b0;
    #1;
    checkOutput("t6_rst_received", port_received, 0);
    checkOutput("t6_rst_valid", out_valid, 0);
    checkOutput("t6_rst_data", out_data, 8'h00);
    checkOutput("t6_rst_level", fifo_level, 0);
    checkOutput("t6_rst_count", rx_count, 0);
    checkOutput("t6_rst_count_sat", rx_count2, 0);
    checkOutput("t6_rst_err", proto_err, 0);
    applyStimulus(1'b0, 8'h00);
    tick();
    reset = 1'b1;
    tick();

    // Randomized traffic against a randomly stalling consumer
    done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          bit ok;
          sendWord(8'($urandom), $urandom_range(3, 6), ok);
          checkOutput("rand_ack", ok, 1);
        end
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    drain();
    tick();
    checkOutput("rand_sb_empty", sbQ.size(), 0);
    checkOutput("rand_count", rx_count, 40);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/switch_port_rx.md
Name: switch_port_rx

Overview:
- Egress-port receiver at the far end of the switch's per-port request/data/acknowledge interface. One instance sits on each switch output port.
- Accepts a word when port_req is high, acknowledges with a registered one-cycle port_received pulse, and buffers the word in a show-ahead FIFO.
- The FIFO drains through a valid/ready interface. The block also keeps a saturating packet counter and a sticky protocol-error flag.

Parameters:
- DATA_WIDTH, 8, width of one packet word.
- FIFO_DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- CNT_WIDTH, 16, width of the received-packet counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- port_req  input  1  switch request for this port.
- port_data  input  DATA_WIDTH  packet word; valid while port_req=1.
- port_received  output  1  acknowledge to the switch; registered.
- rx_enable  input  1  when 0, no new word is accepted (the switch stalls).
- out_valid  output  1  FIFO not empty.
- out_data  output  DATA_WIDTH  head-of-FIFO word (show-ahead).
- out_ready  input  1  consumer pops the head word when out_valid=1.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- rx_count  output  CNT_WIDTH  accepted packets; saturates at all-ones.
- proto_err  output  1  sticky error flag.
- clr_err  input  1  synchronous clear of proto_err.

Behaviour:
- Reset (reset=0, asynchronous): port_received=0, out_valid=0, out_data=0, fifo_level=0, rx_count=0, proto_err=0, FSM=IDLE, read/write pointers=0, FIFO contents=0.
- The switch drops port_req combinationally in the same cycle port_received is seen. For that reason port_received must come straight from a flop, with no combinational path from port_req.
- FSM state IDLE:
  - If port_req=1, rx_enable=1 and fifo_level<FIFO_DEPTH: write port_data at wr_ptr, increment wr_ptr (wraps modulo FIFO_DEPTH), increment rx_count unless already all-ones, go to ACK.
  - Otherwise stay in IDLE with port_received=0. A held request while the FIFO is full or rx_enable=0 back-pressures the switch indefinitely.
- FSM state ACK:
  - port_received=1 for exactly this one cycle; next state is IDLE unconditionally.
  - If port_req=1 in ACK, set proto_err=1. Nothing is written.
- Latency: request sampled at edge E gives port_received high in cycle E..E+1 and the word visible on out_data from E+1 (if the FIFO was empty).
- Minimum spacing: at most one accept per two cycles by construction. Back-to-back switch requests arrive no closer than 4 cycles apart.
- FIFO read: out_valid = (fifo_level != 0); out_data = mem[rd_ptr]. A pop occurs when out_valid && out_ready: rd_ptr increments and wraps.
- Simultaneous push and pop: fifo_level is unchanged, and both pointers advance.
- Full check uses the registered level only. A pop in the same cycle does not allow a write into a full FIFO.
- out_ready with the FIFO empty: ignored; no underflow and no pointer change.
- rx_enable is sampled only in IDLE. Deasserting it in ACK does not cancel the pulse.
- proto_err priority: if the set condition and clr_err occur in the same cycle, set wins. Otherwise clr_err=1 clears it.
- Reset mid-handshake: port_received drops immediately (asynchronous). Buffered words are lost, and the switch retries from FOUND.

Test Plan:
- Reset, then port_req=1, port_data=0xA5 for one cycle -> port_received=1 in the next cycle only; out_valid=1, out_data=0xA5, fifo_level=1, rx_count=1.
- Four requests (0x01..0x04) with out_ready=0, then a fifth (0x05) held -> 4 acks; fifth gets no ack while fifo_level=4; a single out_ready pop gives out_data=0x02 and the fifth is acked the next cycle, with fifo_level returning to 4.
- rx_enable=0 with port_req held 10 cycles -> port_received stays 0, rx_count unchanged; rx_enable=1 -> ack 1 cycle later.
- port_req held high through the ACK cycle -> proto_err=1 and stays 1; clr_err pulse -> 0; set and clear in the same cycle -> 1.
- out_ready=1 continuously with accept/drain interleaved over 20 words -> the order is preserved across pointer wrap, fifo_level never exceeds 1, and rx_count=20.
- CNT_WIDTH=2, 5 accepts -> rx_count=3 (saturated); reset asserted in an ACK cycle -> port_received=0 immediately and all outputs return to reset values.
